fp_adder_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor. Successor to the combinational single-precision FloatingPointAdder.
- Adds generic exponent/mantissa widths, an add/subtract mode, selectable rounding (round-to-nearest-even or toward-zero), special-value handling, and a valid/ready stream handshake with backpressure.
- Sits between operand-issue logic and result writeback in the FP datapath.

---
 rtl/fp_adder_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: 3-stage pipelined floating-point adder/subtractor with a
// valid/ready stream interface and a single global stall.
module fp_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   Sub,
  input  logic                   Rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Sum,
  output logic                   Cout,
  output logic                   Invalid
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int LZW = $clog2(SW + 1);
  localparam int EW2 = EXP_W + 2;          // signed exponent with headroom
  localparam int RW  = MAN_W + 2;

  logic en;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---------------- stage 1: unpack / swap / align ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               a_nan, b_nan, a_inf, b_inf;
  logic               swap;
  logic               sx_c, sy_c;
  logic [EXP_W-1:0]   ex_c, ey_c, d_c;
  logic [MAN_W-1:0]   mx_c, my_c;
  logic [SW-1:0]      sigx_c, sigy_raw, sigy_c;
  logic               nan_c, inf_c, isign_c;

  // Unpack, flush denormals, order by magnitude and align the smaller operand.
  always_comb begin
    sa     = A[W-1];
    ea     = A[W-2:MAN_W];
    ma     = (ea == '0) ? '0 : A[MAN_W-1:0];
    sb     = B[W-1] ^ Sub;
    eb     = B[W-2:MAN_W];
    mb     = (eb == '0) ? '0 : B[MAN_W-1:0];

    a_nan  = (ea == '1) && (A[MAN_W-1:0] != '0);
    b_nan  = (eb == '1) && (B[MAN_W-1:0] != '0);
    a_inf  = (ea == '1) && (A[MAN_W-1:0] == '0);
    b_inf  = (eb == '1) && (B[MAN_W-1:0] == '0);
    nan_c  = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    inf_c  = (a_inf | b_inf) & ~nan_c;
    isign_c = a_inf ? sa : sb;

    swap   = {eb, mb} > {ea, ma};
    sx_c   = swap ? sb : sa;
    sy_c   = swap ? sa : sb;
    ex_c   = swap ? eb : ea;
    ey_c   = swap ? ea : eb;
    mx_c   = swap ? mb : ma;
    my_c   = swap ? ma : mb;

    sigx_c   = {(ex_c != '0), mx_c, 3'b000};
    sigy_raw = {(ey_c != '0), my_c, 3'b000};
    d_c      = ex_c - ey_c;

    // Past MAN_W+3 positions everything collapses into the sticky bit.
    if (32'(d_c) >= 32'(MAN_W + 3)) begin
      sigy_c = {{(SW-1){1'b0}}, |sigy_raw};
    end else begin
      sigy_c    = sigy_raw >> d_c;
      sigy_c[0] = sigy_c[0] | (|(sigy_raw & ~({SW{1'b1}} << d_c)));
    end
  end

  logic               s1_valid;
  logic               s1_sx, s1_sy, s1_rm;
  logic [EXP_W-1:0]   s1_ex;
  logic [SW-1:0]      s1_sigx, s1_sigy;
  logic               s1_nan, s1_inf, s1_isign;

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sx    <= sx_c;
      s1_sy    <= sy_c;
      s1_rm    <= Rm;
      s1_ex    <= ex_c;
      s1_sigx  <= sigx_c;
      s1_sigy  <= sigy_c;
      s1_nan   <= nan_c;
      s1_inf   <= inf_c;
      s1_isign <= isign_c;
    end
  end

  // ---------------- stage 2: significand add/subtract ----------------
  logic [SW:0] sum_c;

  // Magnitude ordering guarantees the subtraction never goes negative.
  always_comb begin
    if (s1_sx ^ s1_sy) begin
      sum_c = {1'b0, s1_sigx} - {1'b0, s1_sigy};
    end else begin
      sum_c = {1'b0, s1_sigx} + {1'b0, s1_sigy};
    end
  end

  logic               s2_valid;
  logic               s2_sign, s2_zsign, s2_rm;
  logic [EXP_W-1:0]   s2_exp;
  logic [SW:0]        s2_sum;
  logic               s2_nan, s2_inf, s2_isign;

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sx;
      s2_zsign <= s1_sx & s1_sy;
      s2_rm    <= s1_rm;
      s2_exp   <= s1_ex;
      s2_sum   <= sum_c;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_isign <= s1_isign;
    end
  end

  // ---------------- stage 3: normalise / round / pack ----------------
  logic [LZW-1:0]     lz;
  logic               found;
  logic [SW-1:0]      norm;
  logic [EW2-1:0]     e_n, e_f;
  logic               inc;
  logic [RW-1:0]      rnd;
  logic [MAN_W-1:0]   frac;
  logic [W-1:0]       res;
  logic               res_cout, res_inv;

  // Normalise, round and resolve zero/underflow/overflow/special results.
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (!found) begin
        if (s2_sum[SW-1-i]) found = 1'b1;
        else                lz    = lz + LZW'(1);
      end
    end

    if (s2_sum[SW]) begin
      norm = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      e_n  = EW2'(s2_exp) + EW2'(1);
    end else begin
      norm = s2_sum[SW-1:0] << lz;
      e_n  = EW2'(s2_exp) - EW2'(lz);
    end

    inc = ~s2_rm & norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[SW-1:3]} + RW'(inc);
    if (rnd[MAN_W+1]) begin
      frac = rnd[MAN_W:1];
      e_f  = e_n + EW2'(1);
    end else begin
      frac = rnd[MAN_W-1:0];
      e_f  = e_n;
    end

    res      = '0;
    res_cout = 1'b0;
    res_inv  = 1'b0;
    if (s2_nan) begin
      res     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      res_inv = 1'b1;
    end else if (s2_inf) begin
      res = {s2_isign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_sum == '0) begin
      res = {s2_zsign, {(EXP_W+MAN_W){1'b0}}};
    end else if (e_f[EW2-1] || e_f == '0) begin
      res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (e_f >= {2'b00, {EXP_W{1'b1}}}) begin
      res_cout = 1'b1;
      if (s2_rm) res = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else       res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      res = {s2_sign, e_f[EXP_W-1:0], frac};
    end
  end

  // Output register; result fields only load alongside a valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Invalid   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        Sum     <= res;
        Cout    <= res_cout;
        Invalid <= res_inv;
      end
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed-vector bench for fp_adder_pipe (single precision).
module tb_fp_adder_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, Sub, Rm;
  logic        out_valid, out_ready, Cout, Invalid;
  logic [31:0] A, B, Sum;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sub(Sub), .Rm(Rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Invalid(Invalid)
  );

  // Record every result actually handed to the consumer.
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(Sum);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic rm, input logic [31:0] e_sum,
                         input logic e_cout, input logic e_inv);
    int lat;
    A = a; B = b; Sub = sub; Rm = rm; in_valid = 1'b1;
    check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd3);
    check({tag, ".sum"}, 64'(Sum), 64'(e_sum));
    check({tag, ".cout"}, 64'(Cout), 64'(e_cout));
    check({tag, ".inv"}, 64'(Invalid), 64'(e_inv));
    @(posedge clk); #1;
  endtask

  logic [31:0] st_a   [4] = '{32'h40400000, 32'h41CCCCCD, 32'h41200000, 32'hC1200000};
  logic [31:0] st_b   [4] = '{32'h40400000, 32'h4189999A, 32'hC0000000, 32'h40000000};
  logic        st_sub [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] st_exp [4] = '{32'h40C00000, 32'h41066666, 32'h41000000, 32'hC1000000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Sub = 1'b0; Rm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ov",   64'(out_valid), 64'd0);
    check("reset.sum",  64'(Sum),       64'd0);
    check("reset.cout", 64'(Cout),      64'd0);
    check("reset.inv",  64'(Invalid),   64'd0);
    rst = 1'b0;
    #1;
    check("reset.rdy",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    run_one("cancel",   32'hC0933333, 32'h40933333, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    run_one("rne_tie",  32'h41CCCCCD, 32'h4189999A, 1'b0, 1'b0, 32'h422B3334, 1'b0, 1'b0);
    run_one("rtz",      32'h41CCCCCD, 32'h4189999A, 1'b0, 1'b1, 32'h422B3333, 1'b0, 1'b0);
    run_one("sub3m2",   32'h40400000, 32'h40000000, 1'b1, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_one("ovf_rne",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    run_one("ovf_rtz",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 1'b1, 1'b0);
    run_one("inf_ninf", 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
    run_one("inf_one",  32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 1'b0, 1'b0);
    run_one("nan_in",   32'h7FA00000, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
    run_one("denorm",   32'h00000001, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_one("negzero",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0);
    run_one("big_shift",32'h4B800000, 32'h3F800000, 1'b0, 1'b1, 32'h4B800000, 1'b0, 1'b0);

    // Stream with a 5-cycle backpressure window mid-stream.
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bit acc;
          A = st_a[i]; B = st_b[i]; Sub = st_sub[i]; Rm = 1'b0; in_valid = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 30 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
          end
          if (!acc) check("stream.accept", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin
        logic [31:0] snap;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall.ov", 64'(out_valid), 64'd1);
        snap = Sum;
        check("stall.first", 64'(snap), 64'h40C00000);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall.rdy",  64'(in_ready),  64'd0);
          check("stall.hold", 64'(Sum),       64'(snap));
          check("stall.ovh",  64'(out_valid), 64'd1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 40 && got_q.size() < 4; t++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    check("stream.count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("stream.res", 64'(got_q[i]), 64'(st_exp[i]));
      else                  check("stream.res", 64'd0, 64'(st_exp[i]));
    end

    // Reset with two operations in flight.
    got_q.delete();
    A = 32'h40400000; B = 32'h40400000; Sub = 1'b0; Rm = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'h41200000; B = 32'hC0000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst.ov",   64'(out_valid), 64'd0);
    check("rst.sum",  64'(Sum),       64'd0);
    check("rst.cout", 64'(Cout),      64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst.stale", 64'(got_q.size()), 64'd0);
    run_one("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
